uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter for the UART block. It is the transmit-side counterpart of the RX path and uses the same frame format and parity convention. It accepts a parallel byte with a single-cycle valid and serialises it LSB-first onto `TX_OUT`. Each frame is one start bit, DATA_WIDTH data bits, an optional parity bit and one stop bit. Each bit lasts one `clk` cycle; `clk` is the TX baud clock supplied by the clock divider.

## Interface
- DATA_WIDTH, 8, width of the parallel data word.
- clk  in  1  TX baud clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- P_DATA  in  DATA_WIDTH  parallel data to transmit; sampled only on acceptance.
- Data_Valid  in  1  request to transmit P_DATA; accepted only on an edge where busy==0.
- PAR_EN  in  1  1 = insert parity bit; sampled on acceptance.
- PAR_TYP  in  1  0 = even parity (XOR of data), 1 = odd parity (XNOR of data); sampled on acceptance.
- TX_OUT  out  1  serial line, registered; idle level 1.
- busy  out  1  registered; high from start bit through stop bit.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Reset values: state=IDLE, TX_OUT=1, busy=0, bit counter=0, data/parity latches=0.
- IDLE:
  - TX_OUT=1, busy=0.
  - On an edge with Data_Valid=1: latch P_DATA, PAR_EN, PAR_TYP, compute the parity bit from the latched data, go to START.
- START: TX_OUT=0, busy=1. Next edge goes to DATA with counter=0.
- DATA:
  - TX_OUT=latched_data[counter]; counter increments each edge.
  - After bit DATA_WIDTH-1, go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: TX_OUT=parity bit (even: ^data; odd: ~^data). Next edge goes to STOP.
- STOP: TX_OUT=1, busy=1. Next edge goes to IDLE (busy=0).
- Data_Valid while busy=1 is ignored; it is not queued.
- P_DATA/PAR_EN/PAR_TYP changes mid-frame have no effect on the current frame.
- Data_Valid held high continuously: a new frame starts on every first IDLE edge (one idle bit between frames).
- Reset mid-frame:
  - TX_OUT goes to 1 and busy to 0 immediately, asynchronously.
  - The frame is aborted and never resumed.
  - After release, the block waits in IDLE for a new Data_Valid.
- Counter width is $clog2(DATA_WIDTH); no wrap beyond DATA_WIDTH-1.

## Timing
- Acceptance edge k (Data_Valid=1, state IDLE): after edge k, TX_OUT=0 and busy=1.
- Data bit i is driven after edge k+1+i, for i=0..DATA_WIDTH-1.
- Parity enabled:
  - Parity bit after edge k+1+DATA_WIDTH.
  - Stop bit after edge k+2+DATA_WIDTH.
  - IDLE (busy=0) after edge k+3+DATA_WIDTH.
- Parity disabled:
  - Stop bit after edge k+1+DATA_WIDTH.
  - IDLE after edge k+2+DATA_WIDTH.
- busy is high for exactly DATA_WIDTH+3 cycles (parity) or DATA_WIDTH+2 cycles (no parity).
- Minimum frame period is busy length + 1 idle cycle: 12 / 11 cycles at DATA_WIDTH=8.
- Latency from Data_Valid edge to start bit on line: 1 edge (registered output).

## Configuration
- UART_TX_PARITY_EN defined: PARITY state and parity generator present; PAR_EN/PAR_TYP behave as above.
- Not defined:
  - Parity logic and PARITY state are removed; PAR_EN and PAR_TYP ports remain but are ignored.
  - Every frame is start + DATA_WIDTH data + stop (DATA_WIDTH+2 bits).

## Test plan
- Assert rst for 3 cycles -> TX_OUT=1, busy=0 throughout; after release, stays idle with Data_Valid=0.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, one-cycle Data_Valid -> TX_OUT per cycle 0,1,0,1,0,0,1,0,1,0,1 (parity 0); busy high 11 cycles, then TX_OUT=1, busy=0.
- Same with PAR_TYP=1 -> identical frame except parity bit=1.
- P_DATA=0x3C, PAR_EN=0 -> TX_OUT 0,0,0,1,1,1,1,0,0,1; busy high 10 cycles. Same frame with UART_TX_PARITY_EN undefined and PAR_EN=1.
- During a 0xA5 frame, change P_DATA to 0xFF and hold Data_Valid=1 -> 0xA5 frame unaltered; 0xFF frame starts exactly one idle cycle after busy falls.
- rst asserted asynchronously during data bit 3 -> TX_OUT=1 and busy=0 before the next clk edge; no further bits after release until a new Data_Valid.

Source files
------------

// File: rtl/uart_tx_if.sv
// Handshake and serial-line bundle for uart_tx: parallel byte request in, line and busy out.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        input  TX_OUT, busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        output TX_OUT, busy
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity, stop; one bit per clk.
// Define UART_TX_PARITY_EN to build the parity generator and PARITY state.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                state;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      next_cnt;
    logic                  tx_q;
    logic                  busy_q;

`ifdef UART_TX_PARITY_EN
    logic par_en_reg;
    logic par_bit;
`else
    logic unused_par_inputs;
    assign unused_par_inputs = bus.PAR_EN ^ bus.PAR_TYP;
`endif

    assign next_cnt   = bit_cnt + 1'b1;
    assign bus.TX_OUT = tx_q;
    assign bus.busy   = busy_q;

    // tx_q always carries the level for the state being entered, so the line is a clean register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            bit_cnt  <= '0;
            data_reg <= '0;
`ifdef UART_TX_PARITY_EN
            par_en_reg <= 1'b0;
            par_bit    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (bus.Data_Valid) begin
                        data_reg <= bus.P_DATA;
`ifdef UART_TX_PARITY_EN
                        par_en_reg <= bus.PAR_EN;
                        par_bit    <= bus.PAR_TYP ? ~^bus.P_DATA : ^bus.P_DATA;
`endif
                        state  <= START;
                        tx_q   <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                START: begin
                    state   <= DATA;
                    bit_cnt <= '0;
                    tx_q    <= data_reg[0];
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        if (par_en_reg) begin
                            state <= PARITY;
                            tx_q  <= par_bit;
                        end else begin
                            state <= STOP;
                            tx_q  <= 1'b1;
                        end
`else
                        state <= STOP;
                        tx_q  <= 1'b1;
`endif
                    end else begin
                        bit_cnt <= next_cnt;
                        tx_q    <= data_reg[next_cnt];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    state <= STOP;
                    tx_q  <= 1'b1;
                end
`endif
                STOP: begin
                    state  <= IDLE;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Randomized self-checking bench for uart_tx against a frame-level reference model.
module tb_uart_tx;
    localparam int W = 8;

`ifdef UART_TX_PARITY_EN
    localparam bit PARITY_BUILT = 1'b1;
`else
    localparam bit PARITY_BUILT = 1'b0;
`endif

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic exp_bits[$];

    uart_tx_if #(.DATA_WIDTH(W)) bus ();

    uart_tx #(.DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a frame is the list of line levels seen after each edge, derived from the bit order alone
    task automatic build_frame(input logic [W-1:0] d, input logic pe, input logic pt);
        int ones;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < W; i++) exp_bits.push_back(d[i]);
        if (PARITY_BUILT && pe) begin
            ones = $countones(d);
            exp_bits.push_back(((ones % 2) == 1) ^ pt);
        end
        exp_bits.push_back(1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.Data_Valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_hold cyc %0d: tx=%b busy=%b, want tx=1 busy=0", c, bus.TX_OUT, bus.busy);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_idle cyc %0d: tx=%b busy=%b, want tx=1 busy=0", c, bus.TX_OUT, bus.busy);
            end
        end
    endtask

    task automatic test_single_frame(input logic [W-1:0] d, input logic pe, input logic pt, input string tag);
        build_frame(d, pe, pt);
        bus.P_DATA = d;
        bus.PAR_EN = pe;
        bus.PAR_TYP = pt;
        bus.Data_Valid = 1'b1;
        tick();
        bus.Data_Valid = 1'b0;
        for (int i = 0; i < exp_bits.size(); i++) begin
            checks++;
            if (bus.TX_OUT !== exp_bits[i] || bus.busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s bit %0d: tx=%b busy=%b, want tx=%b busy=1", tag, i, bus.TX_OUT, bus.busy, exp_bits[i]);
            end
            tick();
        end
        checks++;
        if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s end_idle: tx=%b busy=%b, want tx=1 busy=0", tag, bus.TX_OUT, bus.busy);
        end
    endtask

    // Inputs are scrambled and Data_Valid toggled while busy; none of it may leak into the frame
    task automatic test_random_frames();
        logic [W-1:0] d;
        logic pe;
        logic pt;
        for (int f = 0; f < 20; f++) begin
            d  = W'($urandom);
            pe = 1'($urandom);
            pt = 1'($urandom);
            build_frame(d, pe, pt);
            bus.P_DATA = d;
            bus.PAR_EN = pe;
            bus.PAR_TYP = pt;
            bus.Data_Valid = 1'b1;
            tick();
            for (int i = 0; i < exp_bits.size(); i++) begin
                checks++;
                if (bus.TX_OUT !== exp_bits[i] || bus.busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL rand f%0d d=%h bit %0d: tx=%b busy=%b, want tx=%b busy=1", f, d, i, bus.TX_OUT, bus.busy, exp_bits[i]);
                end
                bus.P_DATA = W'($urandom);
                bus.PAR_EN = 1'($urandom);
                bus.PAR_TYP = 1'($urandom);
                bus.Data_Valid = (i == exp_bits.size() - 1) ? 1'b0 : 1'($urandom);
                tick();
            end
            checks++;
            if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rand f%0d idle: tx=%b busy=%b, want tx=1 busy=0", f, bus.TX_OUT, bus.busy);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] frames [2];
        frames[0] = 8'hA5;
        frames[1] = 8'hFF;
        bus.P_DATA = frames[0];
        bus.PAR_EN = 1'b1;
        bus.PAR_TYP = 1'b0;
        bus.Data_Valid = 1'b1;
        tick();
        bus.P_DATA = frames[1];
        for (int f = 0; f < 2; f++) begin
            build_frame(frames[f], 1'b1, 1'b0);
            for (int i = 0; i < exp_bits.size(); i++) begin
                checks++;
                if (bus.TX_OUT !== exp_bits[i] || bus.busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b frame %0d bit %0d: tx=%b busy=%b, want tx=%b busy=1", f, i, bus.TX_OUT, bus.busy, exp_bits[i]);
                end
                if (f == 1 && i == exp_bits.size() - 1) bus.Data_Valid = 1'b0;
                tick();
            end
            checks++;
            if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b frame %0d gap: tx=%b busy=%b, want tx=1 busy=0", f, bus.TX_OUT, bus.busy);
            end
            tick();
        end
        checks++;
        if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b after: tx=%b busy=%b, want tx=1 busy=0", bus.TX_OUT, bus.busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        bus.P_DATA = 8'hA5;
        bus.PAR_EN = 1'b1;
        bus.PAR_TYP = 1'b0;
        bus.Data_Valid = 1'b1;
        tick();
        bus.Data_Valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (bus.TX_OUT !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst bit3: tx=%b busy=%b, want tx=0 busy=1", bus.TX_OUT, bus.busy);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst async: tx=%b busy=%b, want tx=1 busy=0", bus.TX_OUT, bus.busy);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            checks++;
            if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midrst no_resume cyc %0d: tx=%b busy=%b, want tx=1 busy=0", c, bus.TX_OUT, bus.busy);
            end
        end
        test_single_frame(8'h5A, 1'b1, 1'b1, "after_rst");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.P_DATA = '0;
        bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b0;
        bus.Data_Valid = 1'b0;
        $display("[TB] parity build = %0d", PARITY_BUILT);

        test_reset();
        test_single_frame(8'hA5, 1'b1, 1'b0, "even_A5");
        test_single_frame(8'hA5, 1'b1, 1'b1, "odd_A5");
        test_single_frame(8'h3C, 1'b0, 1'b0, "nopar_3C");
        test_single_frame(8'h3C, 1'b1, 1'b0, "par_3C");
        test_single_frame(8'h00, 1'b1, 1'b1, "odd_00");
        test_single_frame(8'hFF, 1'b1, 1'b0, "even_FF");
        test_random_frames();
        test_back_to_back();
        test_reset_mid_frame();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
